// File: rtl/calc_rs_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_rs_if
// Description : Dispatch, CDB and issue bundle for the calculation-class
//               reservation station. The master drives dispatch and CDB
//               traffic; the slave (the station) returns full and issue.
// Revision    : 1.0 - initial release
// ============================================================================

// Instruction type encoding shared by the decode stage and the stations.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`define INST_TYPE_LUI   6'd0
`define INST_TYPE_AUIPC 6'd1
`define INST_TYPE_JAL   6'd2
`define INST_TYPE_JALR  6'd3
`define INST_TYPE_BEQ   6'd4
`define INST_TYPE_BNE   6'd5
`define INST_TYPE_BLT   6'd6
`define INST_TYPE_BGE   6'd7
`define INST_TYPE_BLTU  6'd8
`define INST_TYPE_BGEU  6'd9
`define INST_TYPE_LB    6'd10
`define INST_TYPE_LH    6'd11
`define INST_TYPE_LW    6'd12
`define INST_TYPE_LBU   6'd13
`define INST_TYPE_LHU   6'd14
`define INST_TYPE_SB    6'd15
`define INST_TYPE_SH    6'd16
`define INST_TYPE_SW    6'd17
`define INST_TYPE_ADDI  6'd18
`define INST_TYPE_SLTI  6'd19
`define INST_TYPE_SLTIU 6'd20
`define INST_TYPE_XORI  6'd21
`define INST_TYPE_ORI   6'd22
`define INST_TYPE_ANDI  6'd23
`define INST_TYPE_SLLI  6'd24
`define INST_TYPE_SRLI  6'd25
`define INST_TYPE_SRAI  6'd26
`define INST_TYPE_ADD   6'd27
`define INST_TYPE_SUB   6'd28
`define INST_TYPE_SLL   6'd29
`define INST_TYPE_SLT   6'd30
`define INST_TYPE_SLTU  6'd31
`define INST_TYPE_XOR   6'd32
`define INST_TYPE_SRL   6'd33
`define INST_TYPE_SRA   6'd34
`define INST_TYPE_OR    6'd35
`define INST_TYPE_AND   6'd36
`endif

interface calc_rs_if #(
    parameter int ROB_WIDTH = 4
);
    // dispatch
    logic                        in_valid;
    logic [`INST_TYPE_WIDTH-1:0] in_type;
    logic [31:0]                 in_pc;
    logic [31:0]                 in_imm;
    logic [ROB_WIDTH-1:0]        in_rob_id;
    logic                        in_qj_valid;
    logic [ROB_WIDTH-1:0]        in_qj;
    logic [31:0]                 in_vj;
    logic                        in_qk_valid;
    logic [ROB_WIDTH-1:0]        in_qk;
    logic [31:0]                 in_vk;
    logic                        full_out;
    // common data buses
    logic                        alu_cdb_valid;
    logic [ROB_WIDTH-1:0]        alu_cdb_rob;
    logic [31:0]                 alu_cdb_val;
    logic                        lsb_cdb_valid;
    logic [ROB_WIDTH-1:0]        lsb_cdb_rob;
    logic [31:0]                 lsb_cdb_val;
    // issue
    logic                        out_valid;
    logic [`INST_TYPE_WIDTH-1:0] out_type;
    logic [31:0]                 out_pc;
    logic [31:0]                 out_imm;
    logic [31:0]                 out_v1;
    logic [31:0]                 out_v2;
    logic [ROB_WIDTH-1:0]        out_rob_id;

    modport master (
        output in_valid, in_type, in_pc, in_imm, in_rob_id,
        output in_qj_valid, in_qj, in_vj, in_qk_valid, in_qk, in_vk,
        output alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
        output lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
        input  full_out,
        input  out_valid, out_type, out_pc, out_imm, out_v1, out_v2, out_rob_id
    );

    modport slave (
        input  in_valid, in_type, in_pc, in_imm, in_rob_id,
        input  in_qj_valid, in_qj, in_vj, in_qk_valid, in_qk, in_vk,
        input  alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
        input  lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
        output full_out,
        output out_valid, out_type, out_pc, out_imm, out_v1, out_v2, out_rob_id
    );
endinterface

`default_nettype wire

// File: rtl/calc_rs.sv
`default_nettype none
// ============================================================================
// Module      : calc_rs
// Description : Reservation station for calculation-class instructions
//               (LUI, AUIPC, register and immediate ALU ops). Holds up to
//               RS_SIZE entries, snoops two CDBs for operand tags, and issues
//               the lowest-indexed ready entry once per cycle.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`define INST_TYPE_LUI   6'd0
`define INST_TYPE_AUIPC 6'd1
`define INST_TYPE_ADDI  6'd18
`define INST_TYPE_AND   6'd36
`endif

module calc_rs #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_WIDTH = 4
) (
    input wire logic   clk_in,
    input wire logic   rst_in,
    input wire logic   rdy_in,
    input wire logic   clear_in,
    calc_rs_if.slave   bus
);

    localparam int c_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // entry storage
    logic [RS_SIZE-1:0]          r_busy;
    logic [RS_SIZE-1:0]          r_qj_valid;
    logic [RS_SIZE-1:0]          r_qk_valid;
    logic [ROB_WIDTH-1:0]        r_qj   [RS_SIZE];
    logic [ROB_WIDTH-1:0]        r_qk   [RS_SIZE];
    logic [ROB_WIDTH-1:0]        r_rob  [RS_SIZE];
    logic [31:0]                 r_vj   [RS_SIZE];
    logic [31:0]                 r_vk   [RS_SIZE];
    logic [31:0]                 r_pc   [RS_SIZE];
    logic [31:0]                 r_imm  [RS_SIZE];
    logic [`INST_TYPE_WIDTH-1:0] r_type [RS_SIZE];

    // registered issue port
    logic                        r_out_valid;
    logic [`INST_TYPE_WIDTH-1:0] r_out_type;
    logic [31:0]                 r_out_pc;
    logic [31:0]                 r_out_imm;
    logic [31:0]                 r_out_v1;
    logic [31:0]                 r_out_v2;
    logic [ROB_WIDTH-1:0]        r_out_rob_id;

    logic                        w_is_calc;
    logic                        w_full;
    logic                        w_dispatch;
    logic [RS_SIZE-1:0]          w_ready;
    logic                        w_free_hit;
    logic [c_IDX_W-1:0]          w_free_idx;
    logic                        w_issue_hit;
    logic [c_IDX_W-1:0]          w_issue_idx;
    logic                        w_disp_qj_valid;
    logic [31:0]                 w_disp_vj;
    logic                        w_disp_qk_valid;
    logic [31:0]                 w_disp_vk;

    // Full depends only on the busy bits at cycle start, so a slot being
    // issued this cycle cannot be refilled until the next one.
    assign w_full  = &r_busy;
    assign w_ready = r_busy & ~r_qj_valid & ~r_qk_valid;

    assign w_dispatch = bus.in_valid & w_is_calc & ~w_full & rdy_in & ~clear_in;

    assign bus.full_out   = w_full;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_type   = r_out_type;
    assign bus.out_pc     = r_out_pc;
    assign bus.out_imm    = r_out_imm;
    assign bus.out_v1     = r_out_v1;
    assign bus.out_v2     = r_out_v2;
    assign bus.out_rob_id = r_out_rob_id;

    // Calculation-class decode: LUI, AUIPC and the contiguous ALU block
    always_comb begin
        w_is_calc = 1'b0;
        if ((bus.in_type == `INST_TYPE_LUI) || (bus.in_type == `INST_TYPE_AUIPC))
            w_is_calc = 1'b1;
        else if ((bus.in_type >= `INST_TYPE_ADDI) && (bus.in_type <= `INST_TYPE_AND))
            w_is_calc = 1'b1;
    end

    // Lowest free slot and lowest ready slot (scan downward so the lowest wins)
    always_comb begin
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        w_issue_hit = 1'b0;
        w_issue_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_issue_hit = 1'b1;
                w_issue_idx = c_IDX_W'(i);
            end
        end
    end

    // Dispatch-time forwarding: an operand whose producer is on a CDB right now
    // is stored already resolved, otherwise it would miss the broadcast.
    always_comb begin
        w_disp_qj_valid = bus.in_qj_valid;
        w_disp_vj       = bus.in_vj;
        w_disp_qk_valid = bus.in_qk_valid;
        w_disp_vk       = bus.in_vk;
        if (bus.in_qj_valid && bus.alu_cdb_valid && (bus.alu_cdb_rob == bus.in_qj)) begin
            w_disp_qj_valid = 1'b0;
            w_disp_vj       = bus.alu_cdb_val;
        end else if (bus.in_qj_valid && bus.lsb_cdb_valid && (bus.lsb_cdb_rob == bus.in_qj)) begin
            w_disp_qj_valid = 1'b0;
            w_disp_vj       = bus.lsb_cdb_val;
        end
        if (bus.in_qk_valid && bus.alu_cdb_valid && (bus.alu_cdb_rob == bus.in_qk)) begin
            w_disp_qk_valid = 1'b0;
            w_disp_vk       = bus.alu_cdb_val;
        end else if (bus.in_qk_valid && bus.lsb_cdb_valid && (bus.lsb_cdb_rob == bus.in_qk)) begin
            w_disp_qk_valid = 1'b0;
            w_disp_vk       = bus.lsb_cdb_val;
        end
    end

    // Entry state: flush, CDB wake-up, issue release and dispatch allocation
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy     <= '0;
            r_qj_valid <= '0;
            r_qk_valid <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_rob[i]  <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_pc[i]   <= '0;
                r_imm[i]  <= '0;
                r_type[i] <= '0;
            end
        end else if (clear_in) begin
            r_busy     <= '0;
            r_qj_valid <= '0;
            r_qk_valid <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_valid[i]) begin
                    if (bus.alu_cdb_valid && (bus.alu_cdb_rob == r_qj[i])) begin
                        r_qj_valid[i] <= 1'b0;
                        r_vj[i]       <= bus.alu_cdb_val;
                    end else if (bus.lsb_cdb_valid && (bus.lsb_cdb_rob == r_qj[i])) begin
                        r_qj_valid[i] <= 1'b0;
                        r_vj[i]       <= bus.lsb_cdb_val;
                    end
                end
                if (r_busy[i] && r_qk_valid[i]) begin
                    if (bus.alu_cdb_valid && (bus.alu_cdb_rob == r_qk[i])) begin
                        r_qk_valid[i] <= 1'b0;
                        r_vk[i]       <= bus.alu_cdb_val;
                    end else if (bus.lsb_cdb_valid && (bus.lsb_cdb_rob == r_qk[i])) begin
                        r_qk_valid[i] <= 1'b0;
                        r_vk[i]       <= bus.lsb_cdb_val;
                    end
                end
            end
            if (w_issue_hit)
                r_busy[w_issue_idx] <= 1'b0;
            // the free slot is never the issuing one, both were sampled at cycle start
            if (w_dispatch && w_free_hit) begin
                r_busy[w_free_idx]     <= 1'b1;
                r_type[w_free_idx]     <= bus.in_type;
                r_pc[w_free_idx]       <= bus.in_pc;
                r_imm[w_free_idx]      <= bus.in_imm;
                r_rob[w_free_idx]      <= bus.in_rob_id;
                r_qj[w_free_idx]       <= bus.in_qj;
                r_qk[w_free_idx]       <= bus.in_qk;
                r_qj_valid[w_free_idx] <= w_disp_qj_valid;
                r_vj[w_free_idx]       <= w_disp_vj;
                r_qk_valid[w_free_idx] <= w_disp_qk_valid;
                r_vk[w_free_idx]       <= w_disp_vk;
            end
        end
    end

    // Issue port: one registered issue per cycle, held while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_out_valid  <= 1'b0;
            r_out_type   <= '0;
            r_out_pc     <= '0;
            r_out_imm    <= '0;
            r_out_v1     <= '0;
            r_out_v2     <= '0;
            r_out_rob_id <= '0;
        end else if (clear_in) begin
            r_out_valid <= 1'b0;
        end else if (rdy_in) begin
            r_out_valid <= w_issue_hit;
            if (w_issue_hit) begin
                r_out_type   <= r_type[w_issue_idx];
                r_out_pc     <= r_pc[w_issue_idx];
                r_out_imm    <= r_imm[w_issue_idx];
                r_out_v1     <= r_vj[w_issue_idx];
                r_out_v2     <= r_vk[w_issue_idx];
                r_out_rob_id <= r_rob[w_issue_idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_calc_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_rs
// Description : Directed self-checking bench for calc_rs.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`define INST_TYPE_LUI   6'd0
`define INST_TYPE_AUIPC 6'd1
`define INST_TYPE_BEQ   6'd4
`define INST_TYPE_LW    6'd12
`define INST_TYPE_ADDI  6'd18
`define INST_TYPE_ADD   6'd27
`define INST_TYPE_SUB   6'd28
`define INST_TYPE_AND   6'd36
`endif

module tb_calc_rs;

    localparam int RS_SIZE   = 8;
    localparam int ROB_WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
    logic clear = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    calc_rs_if #(.ROB_WIDTH(ROB_WIDTH)) bus_if();

    calc_rs #(
        .RS_SIZE   (RS_SIZE),
        .ROB_WIDTH (ROB_WIDTH)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst_n),
        .rdy_in   (rdy),
        .clear_in (clear),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, 32'(bus_if.out_valid), 32'd0);
    endtask

    task automatic check_issue(input string tag, input logic [3:0] rob,
                               input logic [31:0] v1, input logic [31:0] v2);
        check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_rob"}, 32'(bus_if.out_rob_id), 32'(rob));
        check({tag, "_v1"}, bus_if.out_v1, v1);
        check({tag, "_v2"}, bus_if.out_v2, v2);
    endtask

    task automatic drive_idle();
        bus_if.in_valid      = 1'b0;
        bus_if.alu_cdb_valid = 1'b0;
        bus_if.lsb_cdb_valid = 1'b0;
    endtask

    task automatic dispatch(input logic [`INST_TYPE_WIDTH-1:0] typ, input logic [3:0] rob,
                            input logic qjv, input logic [3:0] qj, input logic [31:0] vj,
                            input logic qkv, input logic [3:0] qk, input logic [31:0] vk,
                            input logic [31:0] imm, input logic [31:0] pc);
        bus_if.in_valid    = 1'b1;
        bus_if.in_type     = typ;
        bus_if.in_rob_id   = rob;
        bus_if.in_qj_valid = qjv;
        bus_if.in_qj       = qj;
        bus_if.in_vj       = vj;
        bus_if.in_qk_valid = qkv;
        bus_if.in_qk       = qk;
        bus_if.in_vk       = vk;
        bus_if.in_imm      = imm;
        bus_if.in_pc       = pc;
    endtask

    initial begin
        drive_idle();
        bus_if.in_type     = '0;
        bus_if.in_rob_id   = '0;
        bus_if.in_qj_valid = 1'b0;
        bus_if.in_qj       = '0;
        bus_if.in_vj       = '0;
        bus_if.in_qk_valid = 1'b0;
        bus_if.in_qk       = '0;
        bus_if.in_vk       = '0;
        bus_if.in_imm      = '0;
        bus_if.in_pc       = '0;
        bus_if.alu_cdb_rob = '0;
        bus_if.alu_cdb_val = '0;
        bus_if.lsb_cdb_rob = '0;
        bus_if.lsb_cdb_val = '0;

        // reset state
        #1;
        check("rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_full", 32'(bus_if.full_out), 32'd0);
        check("rst_rob", 32'(bus_if.out_rob_id), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ADDI with ready operands: written at edge 0, issued at edge 1
        dispatch(`INST_TYPE_ADDI, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0, 32'd7, 32'h100);
        tick();
        drive_idle();
        check_idle("addi_lat");
        tick();
        check_issue("addi", 4'd3, 32'd5, 32'd0);
        check("addi_imm", bus_if.out_imm, 32'd7);
        check("addi_pc", bus_if.out_pc, 32'h100);
        check("addi_type", 32'(bus_if.out_type), 32'(`INST_TYPE_ADDI));
        tick();
        check_idle("addi_after");

        // ADD waiting on tag 2, woken by the ALU CDB two cycles later
        dispatch(`INST_TYPE_ADD, 4'd4, 1'b1, 4'd2, 32'hBAD, 1'b0, 4'd0, 32'd3, 32'd0, 32'h104);
        tick();
        drive_idle();
        check_idle("wait_disp");
        tick();
        check_idle("wait_1");
        bus_if.alu_cdb_valid = 1'b1;
        bus_if.alu_cdb_rob   = 4'd2;
        bus_if.alu_cdb_val   = 32'h10;
        tick();
        drive_idle();
        check_idle("wait_cdb_edge");
        tick();
        check_issue("wait_wake", 4'd4, 32'h10, 32'd3);

        // dispatch-time forwarding from the ALU CDB
        dispatch(`INST_TYPE_ADD, 4'd5, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 32'd0);
        bus_if.alu_cdb_valid = 1'b1;
        bus_if.alu_cdb_rob   = 4'd6;
        bus_if.alu_cdb_val   = 32'd9;
        tick();
        drive_idle();
        check_idle("fwd_disp");
        tick();
        check_issue("fwd_alu", 4'd5, 32'd9, 32'd1);

        // both operands resolved in one cycle from the two CDBs
        dispatch(`INST_TYPE_SUB, 4'd7, 1'b1, 4'd1, 32'hDEAD, 1'b1, 4'd2, 32'hBEEF, 32'd0, 32'd0);
        tick();
        drive_idle();
        tick();
        check_idle("dual_wait");
        bus_if.alu_cdb_valid = 1'b1;
        bus_if.alu_cdb_rob   = 4'd1;
        bus_if.alu_cdb_val   = 32'h11;
        bus_if.lsb_cdb_valid = 1'b1;
        bus_if.lsb_cdb_rob   = 4'd2;
        bus_if.lsb_cdb_val   = 32'h22;
        tick();
        drive_idle();
        check_idle("dual_cdb_edge");
        tick();
        check_issue("dual", 4'd7, 32'h11, 32'h22);

        // dispatch-time forwarding from the LSB CDB on the second operand
        dispatch(`INST_TYPE_ADD, 4'd8, 1'b0, 4'd0, 32'd1, 1'b1, 4'd9, 32'd0, 32'd0, 32'd0);
        bus_if.lsb_cdb_valid = 1'b1;
        bus_if.lsb_cdb_rob   = 4'd9;
        bus_if.lsb_cdb_val   = 32'h33;
        tick();
        drive_idle();
        tick();
        check_issue("fwd_lsb", 4'd8, 32'd1, 32'h33);

        // fill all entries with operands waiting on tag 15
        for (int i = 0; i < RS_SIZE; i++) begin
            check("fill_notfull", 32'(bus_if.full_out), 32'd0);
            dispatch(`INST_TYPE_ADD, 4'(i), 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'(i), 32'd0, 32'd0);
            tick();
        end
        drive_idle();
        check("fill_full", 32'(bus_if.full_out), 32'd1);
        // ninth dispatch with ready operands must be dropped
        dispatch(`INST_TYPE_ADDI, 4'd9, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive_idle();
        check("ninth_full", 32'(bus_if.full_out), 32'd1);
        check_idle("ninth_idle");
        tick();
        check_idle("ninth_idle2");
        bus_if.alu_cdb_valid = 1'b1;
        bus_if.alu_cdb_rob   = 4'd15;
        bus_if.alu_cdb_val   = 32'h55;
        tick();
        drive_idle();
        check_idle("fill_cdb_edge");
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            check_issue("drain", 4'(i), 32'h55, 32'(i));
            check("drain_notfull", 32'(bus_if.full_out), 32'd0);
        end
        tick();
        check_idle("drain_done");

        // non-calculation types never allocate
        dispatch(`INST_TYPE_LW, 4'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'd0, 32'd0);
        tick();
        dispatch(`INST_TYPE_BEQ, 4'd2, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'd0, 32'd0);
        tick();
        drive_idle();
        check_idle("lw_drop");
        tick();
        check_idle("beq_drop");

        // flush with three ready entries plus a dispatch in the flush cycle
        for (int k = 0; k < 3; k++) begin
            dispatch(`INST_TYPE_ADD, 4'(k + 1), 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
            tick();
        end
        drive_idle();
        bus_if.alu_cdb_valid = 1'b1;
        bus_if.alu_cdb_rob   = 4'd12;
        bus_if.alu_cdb_val   = 32'h40;
        tick();
        drive_idle();
        clear = 1'b1;
        dispatch(`INST_TYPE_ADDI, 4'd6, 1'b0, 4'd0, 32'd6, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
        clear = 1'b0;
        drive_idle();
        check_idle("clr_valid");
        check("clr_full", 32'(bus_if.full_out), 32'd0);
        tick();
        check_idle("clr_stale1");
        tick();
        check_idle("clr_stale2");

        // asynchronous reset in the middle of operation
        dispatch(`INST_TYPE_ADDI, 4'd9, 1'b0, 4'd0, 32'h90, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
        dispatch(`INST_TYPE_ADDI, 4'd10, 1'b0, 4'd0, 32'hA0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive_idle();
        check_issue("prerst", 4'd9, 32'h90, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus_if.out_valid), 32'd0);
        check("arst_rob", 32'(bus_if.out_rob_id), 32'd0);
        check("arst_v1", bus_if.out_v1, 32'd0);
        check("arst_full", 32'(bus_if.full_out), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("postrst1");
        tick();
        check_idle("postrst2");

        // rdy_in low freezes issue and holds the outputs
        dispatch(`INST_TYPE_ADDI, 4'd11, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
        dispatch(`INST_TYPE_ADDI, 4'd12, 1'b0, 4'd0, 32'h12, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive_idle();
        check_issue("stall_pre", 4'd11, 32'h11, 32'd0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_issue("stall_hold", 4'd11, 32'h11, 32'd0);
        end
        rdy = 1'b1;
        tick();
        check_issue("stall_resume", 4'd12, 32'h12, 32'd0);
        tick();
        check_idle("stall_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_rs.md
CALC_RS -- requirements
Module: calc_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, ROB tag width in bits.
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; 0 freezes all state.
REQ-006 SHALL have port clear_in  input  1  mispredict flush.
REQ-007 SHALL have dispatch inputs in_valid 1, in_type `INST_TYPE_WIDTH, in_pc 32, in_imm 32, in_rob_id ROB_WIDTH.
REQ-008 SHALL have per-operand inputs in_qj_valid 1 (1 = waiting on tag), in_qj ROB_WIDTH, in_vj 32, and likewise in_qk_valid, in_qk, in_vk.
REQ-009 SHALL have port full_out  output  1  no free entry this cycle.
REQ-010 SHALL have CDB inputs alu_cdb_valid 1, alu_cdb_rob ROB_WIDTH, alu_cdb_val 32, and lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val of the same widths.
REQ-011 SHALL have issue outputs out_valid 1, out_type `INST_TYPE_WIDTH, out_pc 32, out_imm 32, out_v1 32, out_v2 32, out_rob_id ROB_WIDTH, all registered.

Function
REQ-012 SHALL classify in_type with the codebase calculation-class decode (LUI, AUIPC, R-type ALU, I-type ALU incl. shifts); dispatch SHALL be accepted only when in_valid=1, type is calculation-class, full_out=0, rdy_in=1, clear_in=0.
REQ-013 SHALL silently drop non-calculation types and any dispatch while full_out=1; entry count unchanged.
REQ-014 SHALL write an accepted dispatch into the lowest-indexed non-busy entry at the clock edge.
REQ-015 SHALL compute full_out combinationally from current busy bits only (an issue in the same cycle does not deassert it).
REQ-016 SHALL, for each waiting operand in every busy entry, capture the CDB value and clear its wait flag when a valid CDB tag equals its tag; both CDBs SHALL be checked independently, so qj and qk may resolve in the same cycle.
REQ-017 SHALL forward CDB at dispatch: an operand whose in_q tag matches a valid CDB in the dispatch cycle is stored ready with the CDB value.
REQ-018 SHALL treat an entry as ready when busy and neither operand waits; among ready entries the lowest index issues, at most one per cycle.
REQ-019 SHALL, on issue at edge T, free the entry and drive out_valid=1 with that entry's fields for the cycle after edge T; otherwise out_valid=0 after the edge.
REQ-020 SHALL make an entry eligible to issue no earlier than the edge after it was written or became ready (readiness is registered): dispatch with ready operands at edge T gives out_valid high after edge T+1.
REQ-021 SHALL, when clear_in=1 at an edge, clear all busy bits and out_valid, ignoring dispatch, CDB and issue that cycle; clear_in has priority over everything except reset.
REQ-022 SHALL, when rdy_in=0 and clear_in=0, hold all registers including outputs.
REQ-023 SHALL support the same entry index being freed by issue and reused by dispatch only in different cycles; a same-cycle dispatch uses a slot free at cycle start.

Reset
REQ-024 SHALL, while rst_in=0, clear all busy bits and wait flags and drive out_valid=0, full_out=0, all other outputs 0, independent of clk_in.
REQ-025 SHALL resume normal operation on the first rising edge after rst_in returns to 1; reset mid-operation discards all entries.

Verification
REQ-026 Dispatch ADDI, rob 3, both operands ready, vj=5, imm=7 at edge 0 -> out_valid=1 after edge 1 with out_v1=5, out_imm=7, out_rob_id=3.
REQ-027 Dispatch ADD with qj=2 waiting; alu_cdb rob 2 value 0x10 two cycles later -> issue one edge after the CDB edge with out_v1=0x10.
REQ-028 Dispatch while alu_cdb broadcasts qj's tag 6 with value 9 -> entry stored ready, issues with out_v1=9; same cycle alu_cdb=qj and lsb_cdb=qk -> both captured.
REQ-029 Fill 8 waiting entries -> full_out=1; ninth dispatch dropped; dispatching LW or BEQ in any state -> no entry allocated.
REQ-030 Three ready entries, clear_in pulse -> out_valid=0 and full_out=0 next cycle, no stale issue; rst_in low mid-operation -> all outputs 0 asynchronously.
REQ-031 rdy_in low for 3 cycles with ready entries -> no issue, outputs held; issue resumes the edge after rdy_in returns high.
